// File: rtl/key_debounce_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// key_debounce_scheduler
//
// Debounces NKEYS active-low key pins using a single shared millisecond
// timer. Pending keys take turns on the timer in round-robin order. The
// debounced level of a key is only updated when its raw (synchronised) value
// still differs from the stored level at the end of the debounce window.
//
// Ports
//   CLK          system clock, rising edge
//   RSTn         asynchronous active-low reset
//   Key_In       raw active-low key pins (asynchronous to CLK)
//   Key_Level    debounced key levels, 1 = released
//   Key_Press    one-cycle pulse on a debounced 1->0 change
//   Key_Release  one-cycle pulse on a debounced 0->1 change
//   Busy         high while the shared timer is allocated (WAIT or CHECK)
//   Grant        index of the key currently or most recently owning the timer
// ---------------------------------------------------------------------------
module key_debounce_scheduler #(
    parameter int          NKEYS  = 4,
    parameter logic [15:0] T1MS   = 16'd49_999,
    parameter logic [3:0]  DEB_MS = 4'd10
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [NKEYS-1:0] Key_In,
    output logic [NKEYS-1:0] Key_Level,
    output logic [NKEYS-1:0] Key_Press,
    output logic [NKEYS-1:0] Key_Release,
    output logic             Busy,
    output logic [1:0]       Grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [15:0]      count1_q,   count1_d;
    logic [3:0]       count_ms_q, count_ms_d;
    logic [1:0]       grant_q,    grant_d;
    logic [1:0]       last_q,     last_d;
    logic [NKEYS-1:0] level_q,    level_d;
    logic [NKEYS-1:0] press_q,    press_d;
    logic [NKEYS-1:0] release_q,  release_d;
    logic             busy_q,     busy_d;

    logic [NKEYS-1:0] sync_p0, sync_p1;
    logic [NKEYS-1:0] pending;

    // Round-robin pick: scan starting just after the last served key and
    // wrap around; the 2-bit sum wraps naturally modulo 4.
    function automatic logic [1:0] rr_pick(input logic [NKEYS-1:0] pend,
                                           input logic [1:0]       last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       hit;
        pick = last;
        hit  = 1'b0;
        for (int i = 1; i <= NKEYS; i++) begin
            idx = last + 2'(i);
            if (!hit && pend[idx]) begin
                pick = idx;
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

    // Stage p0/p1: two-flop synchroniser; idle level of the pins is high.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= Key_In;
            sync_p1 <= sync_p0;
        end
    end

    assign pending = sync_p1 ^ level_q;

    always_comb begin
        state_d    = state_q;
        count1_d   = '0;
        count_ms_d = '0;
        grant_d    = grant_q;
        last_d     = last_q;
        level_d    = level_q;
        press_d    = '0;
        release_d  = '0;
        case (state_q)
            IDLE: begin
                if (|pending) begin
                    grant_d = rr_pick(pending, last_q);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The timer runs to completion regardless of what the granted
                // key does meanwhile; only its value at CHECK matters.
                if (count1_q == T1MS) begin
                    if (count_ms_q == DEB_MS - 4'd1) begin
                        state_d = CHECK;
                    end else begin
                        count_ms_d = count_ms_q + 4'd1;
                    end
                end else begin
                    count1_d   = count1_q + 16'd1;
                    count_ms_d = count_ms_q;
                end
            end
            CHECK: begin
                if (sync_p1[grant_q] != level_q[grant_q]) begin
                    level_d[grant_q] = sync_p1[grant_q];
                    if (sync_p1[grant_q]) begin
                        release_d[grant_q] = 1'b1;
                    end else begin
                        press_d[grant_q] = 1'b1;
                    end
                end
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Stage boundary: all state and outputs registered here.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            count1_q   <= '0;
            count_ms_q <= '0;
            grant_q    <= '0;
            last_q     <= 2'd3;
            level_q    <= '1;
            press_q    <= '0;
            release_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count1_q   <= count1_d;
            count_ms_q <= count_ms_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            busy_q     <= busy_d;
        end
    end

    assign Key_Level   = level_q;
    assign Key_Press   = press_q;
    assign Key_Release = release_q;
    assign Busy        = busy_q;
    assign Grant       = grant_q;

endmodule
